// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
//   Shared core definitions used by the fetch stage and the decoder:
//     - state_t     : fetch FSM state encoding (IDLE / FETCH / WAIT / ISSUE)
//     - half_sel_t  : instr_choose encoding (0 = high half, 1 = low half)
//     - LONG_BIT    : position of the long-instruction flag in a word
//     - long_bit()  : the same position for an arbitrary word width
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

  localparam int CORE_WIDTH = 32;

  // The long flag is always the top bit of the instruction word.
  function automatic int long_bit(input int width);
    return width - 1;
  endfunction

  localparam int LONG_BIT = long_bit(CORE_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_ISSUE = 2'd3
  } state_t;

  // Even halfword addresses hold the high half of a word, odd ones the low half.
  typedef enum logic {
    HALF_HI = 1'b0,
    HALF_LO = 1'b1
  } half_sel_t;

endpackage : instr_fetch_pkg

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch stage feeding the instruction decoder. Reads words from a
//   synchronous instruction RAM (1-cycle read latency) and issues one
//   instruction per dec_en pulse: either a full long word (top bit set) or one
//   16-bit half. A word holding two short instructions is fetched once and
//   issued twice. Honours a downstream stall and redirects on jump requests.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   mem_rden          RAM read strobe (decoded from registered state only)
//   mem_addr          RAM word address = pc[WIDTH/2-1:1]
//   mem_q             RAM read data, valid the cycle after mem_rden
//   stall             downstream busy: hold current instruction, issue nothing
//   jump_en/jump_addr one-cycle redirect to a halfword address
//   dec_en            one-cycle issue pulse to the decoder
//   long_instr        held fetched word presented to the decoder
//   instr_choose      0 = high half, 1 = low half of long_instr
//   pc_out            halfword address of the issued instruction
//   align_err         pulse with dec_en when a long word is issued at odd pc
// -----------------------------------------------------------------------------
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                     WIDTH    = 32,
  parameter logic [WIDTH/2-1:0]     RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   mem_rden,
  output logic [WIDTH/2-2:0]     mem_addr,
  input  logic [WIDTH-1:0]       mem_q,
  input  logic                   stall,
  input  logic                   jump_en,
  input  logic [WIDTH/2-1:0]     jump_addr,
  output logic                   dec_en,
  output logic [WIDTH-1:0]       long_instr,
  output logic                   instr_choose,
  output logic [WIDTH/2-1:0]     pc_out,
  output logic                   align_err
);

  localparam int HW = WIDTH / 2;
  localparam int LB = long_bit(WIDTH);

  localparam logic [HW-1:0] PC_ONE = HW'(1);
  localparam logic [HW-1:0] PC_TWO = HW'(2);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [HW-1:0]      pc_q, pc_d;
  logic [WIDTH-1:0]   ir_q, ir_d;

  logic               dec_en_q, dec_en_d;
  logic [WIDTH-1:0]   long_instr_q, long_instr_d;
  half_sel_t          instr_choose_q, instr_choose_d;
  logic [HW-1:0]      pc_out_q, pc_out_d;
  logic               align_err_q, align_err_d;

  // ---------------------------------------------------------------------------
  // Decoded conditions
  // ---------------------------------------------------------------------------
  logic redirect;     // jump accepted this cycle
  logic issue;        // instruction handed to the decoder this cycle
  logic ir_is_long;
  logic pc_odd;

  assign ir_is_long = ir_q[LB];
  assign pc_odd     = pc_q[0];
  // A jump wins over both stall and issue; it is ignored while still in IDLE.
  assign redirect   = jump_en && (state_q != S_IDLE);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: state_d = S_WAIT;
      S_WAIT:  state_d = S_ISSUE;
      S_ISSUE: begin
        if (!stall) begin
          // Only a short in the high half leaves a second instruction in ir.
          if (pc_odd || ir_is_long) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect) begin
      state_d = S_FETCH;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode
  // mem_rden/mem_addr come purely from registered state and pc so the RAM
  // interface has no combinational path from any input.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_rden = (state_q == S_FETCH);
    issue    = (state_q == S_ISSUE) && !stall && !jump_en;
  end

  assign mem_addr = pc_q[HW-1:1];

  // ---------------------------------------------------------------------------
  // Instruction register: capture RAM data in WAIT unless a jump discards the
  // in-flight read.
  // ---------------------------------------------------------------------------
  always_comb begin
    ir_d = ir_q;
    if ((state_q == S_WAIT) && !jump_en) begin
      ir_d = mem_q;
    end
  end

  // ---------------------------------------------------------------------------
  // PC next-value mux: jump / +2 (aligned long) / +1 (any half) / hold.
  // Arithmetic wraps naturally at the pc width.
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = jump_addr;
    end else if (issue) begin
      if (ir_is_long && !pc_odd) begin
        pc_d = pc_q + PC_TWO;
      end else begin
        // Short at either half, or a misaligned long: step one halfword.
        pc_d = pc_q + PC_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      ir_q <= '0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered decoder-facing outputs. Data outputs hold their last issued
  // value between pulses so the decoder sees a stable instruction.
  // ---------------------------------------------------------------------------
  always_comb begin
    dec_en_d       = issue;
    align_err_d    = issue && pc_odd && ir_is_long;
    long_instr_d   = long_instr_q;
    instr_choose_d = instr_choose_q;
    pc_out_d       = pc_out_q;
    if (issue) begin
      long_instr_d   = ir_q;
      instr_choose_d = pc_odd ? HALF_LO : HALF_HI;
      pc_out_d       = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_en_q       <= 1'b0;
      long_instr_q   <= '0;
      instr_choose_q <= HALF_HI;
      pc_out_q       <= RESET_PC;
      align_err_q    <= 1'b0;
    end else begin
      dec_en_q       <= dec_en_d;
      long_instr_q   <= long_instr_d;
      instr_choose_q <= instr_choose_d;
      pc_out_q       <= pc_out_d;
      align_err_q    <= align_err_d;
    end
  end

  assign dec_en       = dec_en_q;
  assign long_instr   = long_instr_q;
  assign instr_choose = instr_choose_q;
  assign pc_out       = pc_out_q;
  assign align_err    = align_err_q;

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Directed bench for instr_fetch with a behavioural 1-cycle-latency RAM.
//   Edges are counted from the reset release; outputs are sampled 1 time unit
//   after each rising edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_rden;
  logic [14:0] mem_addr;
  logic [31:0] mem_q = '0;
  logic        stall = 1'b0;
  logic        jump_en = 1'b0;
  logic [15:0] jump_addr = '0;
  logic        dec_en;
  logic [31:0] long_instr;
  logic        instr_choose;
  logic [15:0] pc_out;
  logic        align_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram [0:32767];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rden) mem_q <= ram[mem_addr];
  end

  // One line per issued instruction.
  always @(negedge clk) begin
    if (dec_en)
      $display("issue pc=%h choose=%0b instr=%h align_err=%0b", pc_out, instr_choose, long_instr, align_err);
  end

  instr_fetch #(.WIDTH(32), .RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_rden     (mem_rden),
    .mem_addr     (mem_addr),
    .mem_q        (mem_q),
    .stall        (stall),
    .jump_en      (jump_en),
    .jump_addr    (jump_addr),
    .dec_en       (dec_en),
    .long_instr   (long_instr),
    .instr_choose (instr_choose),
    .pc_out       (pc_out),
    .align_err    (align_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 32768; i++) ram[i] = '0;
  endtask

  // Holds reset for two edges and releases it 1 unit after an edge; the next
  // rising edge is edge 1.
  task automatic reset_dut();
    stall = 1'b0;
    jump_en = 1'b0;
    jump_addr = '0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // RAM[0] = 1234_5678 must already be loaded and reset just released.
  task automatic run_first_scenario(input string tag);
    for (int e = 1; e <= 3; e++) begin
      step();
      checks++; if (dec_en !== 1'b0) begin errors++; $display("FAIL %s_bubble%0d dec_en got %b want 0", tag, e, dec_en); end
      if (e == 1) begin
        checks++; if (mem_rden !== 1'b1 || mem_addr !== 15'd0) begin errors++; $display("FAIL %s_fetch0 rden/addr got %b/%h want 1/0000", tag, mem_rden, mem_addr); end
      end
    end
    step(); // edge 4
    checks++; if (dec_en !== 1'b1 || instr_choose !== 1'b0 || pc_out !== 16'h0000 || long_instr !== 32'h1234_5678)
      begin errors++; $display("FAIL %s_edge4 en/choose/pc/instr got %b/%b/%h/%h want 1/0/0000/12345678", tag, dec_en, instr_choose, pc_out, long_instr); end
    checks++; if (mem_rden !== 1'b0) begin errors++; $display("FAIL %s_edge4_rden got %b want 0", tag, mem_rden); end
    step(); // edge 5
    checks++; if (dec_en !== 1'b1 || instr_choose !== 1'b1 || pc_out !== 16'h0001)
      begin errors++; $display("FAIL %s_edge5 en/choose/pc got %b/%b/%h want 1/1/0001", tag, dec_en, instr_choose, pc_out); end
    checks++; if (mem_rden !== 1'b1 || mem_addr !== 15'd1) begin errors++; $display("FAIL %s_refetch rden/addr got %b/%h want 1/0001", tag, mem_rden, mem_addr); end
    step(); // edge 6
    checks++; if (dec_en !== 1'b0) begin errors++; $display("FAIL %s_edge6 dec_en got %b want 0", tag, dec_en); end
  endtask

  task automatic test_reset();
    clear_ram();
    ram[0] = 32'h1234_5678;
    rst_n = 1'b0;
    step();
    checks++; if (dec_en !== 1'b0 || mem_rden !== 1'b0 || mem_addr !== 15'd0 || long_instr !== 32'd0 ||
                  instr_choose !== 1'b0 || pc_out !== 16'd0 || align_err !== 1'b0)
      begin errors++; $display("FAIL reset_values en/rden/addr/instr/choose/pc/aerr got %b/%b/%h/%h/%b/%h/%b", dec_en, mem_rden, mem_addr, long_instr, instr_choose, pc_out, align_err); end
    reset_dut();
    run_first_scenario("short_pair");
  endtask

  task automatic test_long();
    clear_ram();
    ram[0] = 32'h8C00_00AB;
    ram[1] = 32'h0000_1111;
    reset_dut();
    repeat (4) step(); // edge 4
    checks++; if (dec_en !== 1'b1 || pc_out !== 16'h0000 || long_instr !== 32'h8C00_00AB || instr_choose !== 1'b0 || align_err !== 1'b0)
      begin errors++; $display("FAIL long_issue en/pc/instr/choose/aerr got %b/%h/%h/%b/%b want 1/0000/8c0000ab/0/0", dec_en, pc_out, long_instr, instr_choose, align_err); end
    checks++; if (mem_rden !== 1'b1 || mem_addr !== 15'd1) begin errors++; $display("FAIL long_next_fetch rden/addr got %b/%h want 1/0001", mem_rden, mem_addr); end
    step(); // edge 5
    checks++; if (dec_en !== 1'b0) begin errors++; $display("FAIL long_single dec_en got %b want 0", dec_en); end
    repeat (2) step(); // edge 7
    checks++; if (dec_en !== 1'b1 || pc_out !== 16'h0002 || instr_choose !== 1'b0 || long_instr !== 32'h0000_1111)
      begin errors++; $display("FAIL long_after en/pc/choose/instr got %b/%h/%b/%h want 1/0002/0/00001111", dec_en, pc_out, instr_choose, long_instr); end
  endtask

  task automatic test_stall();
    int seen;
    clear_ram();
    ram[0] = 32'h8C00_00AB;
    reset_dut();
    repeat (3) step(); // edge 3: now in ISSUE
    stall = 1'b1;
    seen = 0;
    for (int e = 4; e <= 8; e++) begin
      step();
      if (dec_en !== 1'b0 || mem_rden !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL stall_hold active cycles got %0d want 0", seen); end
    stall = 1'b0;
    step(); // edge 9
    checks++; if (dec_en !== 1'b1 || long_instr !== 32'h8C00_00AB || pc_out !== 16'h0000)
      begin errors++; $display("FAIL stall_release en/instr/pc got %b/%h/%h want 1/8c0000ab/0000", dec_en, long_instr, pc_out); end
  endtask

  task automatic test_jump_wait();
    clear_ram();
    ram[0] = 32'h1234_5678;
    ram[9] = 32'h1111_2222;
    reset_dut();
    repeat (2) step(); // edge 2: in WAIT
    jump_en = 1'b1;
    jump_addr = 16'h0013;
    step(); // edge 3
    jump_en = 1'b0;
    checks++; if (mem_rden !== 1'b1 || mem_addr !== 15'h0009 || dec_en !== 1'b0)
      begin errors++; $display("FAIL jump_refetch rden/addr/en got %b/%h/%b want 1/0009/0", mem_rden, mem_addr, dec_en); end
    step(); // edge 4
    checks++; if (dec_en !== 1'b0) begin errors++; $display("FAIL jump_discard dec_en got %b want 0", dec_en); end
    step(); // edge 5
    checks++; if (dec_en !== 1'b0) begin errors++; $display("FAIL jump_bubble dec_en got %b want 0", dec_en); end
    step(); // edge 6
    checks++; if (dec_en !== 1'b1 || instr_choose !== 1'b1 || pc_out !== 16'h0013 || long_instr !== 32'h1111_2222 || align_err !== 1'b0)
      begin errors++; $display("FAIL jump_target en/choose/pc/instr/aerr got %b/%b/%h/%h/%b want 1/1/0013/11112222/0", dec_en, instr_choose, pc_out, long_instr, align_err); end
  endtask

  task automatic test_align();
    clear_ram();
    ram[0] = 32'h9000_00CC;
    reset_dut();
    repeat (2) step();
    jump_en = 1'b1;
    jump_addr = 16'h0001;
    step(); // edge 3
    jump_en = 1'b0;
    repeat (3) step(); // edge 6
    checks++; if (dec_en !== 1'b1 || align_err !== 1'b1 || pc_out !== 16'h0001 || instr_choose !== 1'b1)
      begin errors++; $display("FAIL align_pulse en/aerr/pc/choose got %b/%b/%h/%b want 1/1/0001/1", dec_en, align_err, pc_out, instr_choose); end
    checks++; if (mem_rden !== 1'b1 || mem_addr !== 15'd1) begin errors++; $display("FAIL align_next rden/addr got %b/%h want 1/0001 (pc 0002)", mem_rden, mem_addr); end
    step();
    checks++; if (align_err !== 1'b0 || dec_en !== 1'b0) begin errors++; $display("FAIL align_oneshot aerr/en got %b/%b want 0/0", align_err, dec_en); end

    // Long at the top of the address space wraps to word 0.
    clear_ram();
    ram[15'h7FFF] = 32'hC000_0001;
    reset_dut();
    repeat (2) step();
    jump_en = 1'b1;
    jump_addr = 16'hFFFE;
    step();
    jump_en = 1'b0;
    checks++; if (mem_addr !== 15'h7FFF) begin errors++; $display("FAIL wrap_fetch addr got %h want 7fff", mem_addr); end
    repeat (3) step();
    checks++; if (dec_en !== 1'b1 || pc_out !== 16'hFFFE || instr_choose !== 1'b0 || align_err !== 1'b0 || long_instr !== 32'hC000_0001)
      begin errors++; $display("FAIL wrap_issue en/pc/choose/aerr/instr got %b/%h/%b/%b/%h want 1/fffe/0/0/c0000001", dec_en, pc_out, instr_choose, align_err, long_instr); end
    checks++; if (mem_rden !== 1'b1 || mem_addr !== 15'd0) begin errors++; $display("FAIL wrap_next rden/addr got %b/%h want 1/0000", mem_rden, mem_addr); end
  endtask

  task automatic test_async_reset();
    clear_ram();
    ram[0] = 32'h1234_5678;
    reset_dut();
    repeat (4) step(); // edge 4: issuing, outputs non-reset
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (dec_en !== 1'b0 || mem_rden !== 1'b0 || mem_addr !== 15'd0 || long_instr !== 32'd0 ||
                  instr_choose !== 1'b0 || pc_out !== 16'd0 || align_err !== 1'b0)
      begin errors++; $display("FAIL async_reset en/rden/addr/instr/choose/pc/aerr got %b/%b/%h/%h/%b/%h/%b", dec_en, mem_rden, mem_addr, long_instr, instr_choose, pc_out, align_err); end
    reset_dut();
    run_first_scenario("restart");
  endtask

  initial begin
    test_reset();
    test_long();
    test_stall();
    test_jump_wait();
    test_align();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_instr_fetch
